// File: rtl/hilo_sequencer.sv
// hilo_sequencer: HI/LO unit with 32-step shift-add multiply and restoring divide, sign fix-up in FIX.
// Define HILO_SEQUENCER_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_up;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_step_up;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Signed variants (MULT, DIV) are the even ctrl codes.
    assign w_a_neg = ~ctrl[0] & A[WIDTH-1];
    assign w_b_neg = ~ctrl[0] & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~A + WIDTH'(1)) : A;
    assign w_b_mag = w_b_neg ? (~B + WIDTH'(1)) : B;

    // Multiply: r_up:r_lo is the product register, multiplier bits shift out of r_lo.
    assign w_sum      = {1'b0, r_up} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_prod     = {r_up, r_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

`ifdef HILO_SEQUENCER_DIV_EN
    logic               r_is_div;
    logic               r_neg_r;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_sub;
    logic               w_fit;

    // Divide: r_up is the partial remainder, the dividend shifts out of r_lo as quotient bits shift in.
    assign w_shift = {r_up, r_lo[WIDTH-1]};
    assign w_fit   = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_step_up = w_sum[WIDTH:1];
        w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        w_fix_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo  = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            w_step_up = w_fit ? w_sub : w_shift[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_fit};
            w_fix_hi  = r_neg_r ? (~r_up + WIDTH'(1)) : r_up;
            w_fix_lo  = r_neg_q ? (~r_lo + WIDTH'(1)) : r_lo;
        end
    end
`else
    assign w_step_up = w_sum[WIDTH:1];
    assign w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_fix_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo  = w_prod_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_b      <= '0;
            r_up     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
`ifdef HILO_SEQUENCER_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        case (ctrl)
                            3'd0, 3'd1: begin
                                r_state  <= S_ITER;
                                busy     <= 1'b1;
                                r_cnt    <= 5'd31;
                                r_b      <= w_b_mag;
                                r_up     <= '0;
                                r_lo     <= w_a_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
`ifdef HILO_SEQUENCER_DIV_EN
                                r_is_div <= 1'b0;
                                r_neg_r  <= 1'b0;
`endif
                            end
`ifdef HILO_SEQUENCER_DIV_EN
                            3'd2, 3'd3: begin
                                r_state  <= S_ITER;
                                busy     <= 1'b1;
                                r_cnt    <= 5'd31;
                                r_b      <= w_b_mag;
                                r_up     <= '0;
                                r_lo     <= w_a_mag;
                                // Divide-by-zero keeps the all-ones quotient unsigned.
                                r_neg_q  <= (w_a_neg ^ w_b_neg) && (B != '0);
                                r_neg_r  <= w_a_neg;
                                r_is_div <= 1'b1;
                            end
`endif
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_ITER: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_up <= w_step_up;
                        r_lo <= w_step_lo;
                        if (r_cnt == 5'd0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (!flush) begin
                        HI   <= w_fix_hi;
                        LO   <= w_fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: directed vector table, control corner sequences, randomized ops vs arithmetic model.
module tb_hilo_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, flush, busy, done;
    logic [2:0]  ctrl;
    logic [31:0] A, B, HI, LO;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          eb;
    } vec_t;
    vec_t vecs[$];

    hilo_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output int eb);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = m_hi;
        el = m_lo;
        eb = 0;
        case (c)
            3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; eb = 33; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; eb = 33; end
`ifdef HILO_SEQUENCER_DIV_EN
            3'd2: begin
                eb = 33;
                if (b == 32'd0) begin eh = a; el = 32'hFFFFFFFF; end
                else begin
                    p = 64'(sa / sb); el = p[31:0];
                    p = 64'(sa % sb); eh = p[31:0];
                end
            end
            3'd3: begin
                eb = 33;
                if (b == 32'd0) begin eh = a; el = 32'hFFFFFFFF; end
                else begin el = a / b; eh = a % b; end
            end
`endif
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endfunction

    // Issue one op from an idle block and observe 40 cycles after acceptance.
    task automatic apply(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int eb, input string nm);
        int nb = 0;
        int nd = 0;
        start = 1'b1; ctrl = c; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (eb != 0 && i == 32) begin
                check($sformatf("%s hold HI", nm), 64'(HI), 64'(m_hi));
                check($sformatf("%s hold LO", nm), 64'(LO), 64'(m_lo));
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s busy cycles", nm), 64'(nb), 64'(eb));
        check($sformatf("%s done pulses", nm), 64'(nd), (eb != 0) ? 64'd1 : 64'd0);
        check($sformatf("%s HI", nm), 64'(HI), 64'(eh));
        check($sformatf("%s LO", nm), 64'(LO), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) check("wait_idle timeout", 64'(n), 64'd0);
    endtask

    initial begin
        int          n, nb, nd, eb;
        logic [2:0]  c;
        logic [31:0] a, b, eh, el;

        reset = 1'b0; start = 1'b0; flush = 1'b0; ctrl = '0; A = '0; B = '0;
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0});
        vecs.push_back('{3'd5, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0});
        vecs.push_back('{3'd6, 32'h11111111, 32'd5,        32'h12345678, 32'h9ABCDEF0, 0});
        vecs.push_back('{3'd7, 32'h22222222, 32'd7,        32'h12345678, 32'h9ABCDEF0, 0});
`ifdef HILO_SEQUENCER_DIV_EN
        vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33});
        vecs.push_back('{3'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33});
        vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
        vecs.push_back('{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33});
`else
        vecs.push_back('{3'd3, 32'd100,      32'd0,        32'h12345678, 32'h9ABCDEF0, 0});
        vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,        32'h12345678, 32'h9ABCDEF0, 0});
`endif
        foreach (vecs[i])
            apply(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].eb,
                  $sformatf("vec%0d", i));

        // Start issued mid-operation is ignored.
        start = 1'b1; ctrl = 3'd0; A = 32'd7; B = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; ctrl = 3'd4; A = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(n);
        check("stall busy tail", 64'(n), 64'd28);
        check("stall done", 64'(done), 64'd1);
        check("stall HI", 64'(HI), 64'd0);
        check("stall LO", 64'(LO), 64'd63);
        @(posedge clk); #1;
        check("stall done width", 64'(done), 64'd0);
        check("stall no late MTHI", 64'(HI), 64'd0);
        m_hi = 32'd0; m_lo = 32'd63;

        // Flush at busy cycle 10.
        start = 1'b1; ctrl = 3'd0; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush HI", 64'(HI), 64'd0);
        check("flush LO", 64'(LO), 64'd63);
        nb = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(posedge clk); #1;
        end
        check("flush no done", 64'(nd), 64'd0);
        check("flush stays idle", 64'(nb), 64'd0);
        check("flush LO after", 64'(LO), 64'd63);

        // Flush together with start in IDLE discards the start.
        start = 1'b1; flush = 1'b1; ctrl = 3'd5; A = 32'h00001234;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start LO", 64'(LO), 64'd63);
        check("flush+start busy", 64'(busy), 64'd0);

        // Asynchronous reset at busy cycle 20.
        start = 1'b1; ctrl = 3'd0; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre-reset busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset HI", 64'(HI), 64'd0);
        check("async reset LO", 64'(LO), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        #3 reset = 1'b1;
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        check("post-reset idle", 64'(busy), 64'd0);
        apply(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 33, "post-reset MULT");

        for (int k = 0; k < 30; k++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            model(c, a, b, eh, el, eb);
            apply(c, a, b, eh, el, eb, $sformatf("rand%0d ctrl%0d", k, c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  operation request, sampled on rising clk.
REQ-005 ctrl  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (treated as no-op).
REQ-006 A  input  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 B  input  32  operand B: multiplier or divisor.
REQ-008 flush  input  1  abort of the in-flight operation.
REQ-009 busy  output  1  high while a multi-cycle operation is in flight.
REQ-010 done  output  1  one-cycle pulse on the cycle after HI/LO are updated by a MULT/DIV.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.

Function
REQ-013 The block SHALL implement the states IDLE, ITER and FIX.
- IDLE: start with ctrl 0-3 goes to ITER.
- ITER: after 32 iterations goes to FIX.
- FIX: goes to IDLE after one cycle.
REQ-014 Request acceptance SHALL follow these rules.
- start is accepted only in IDLE.
- start while busy is ignored; the caller stalls.
- Operands are latched on accept and A/B may change afterwards.
REQ-015 MTHI/MTLO accepted in IDLE SHALL write A to HI/LO on the same edge, with no busy and no done.
REQ-016 busy SHALL be high from the edge after a MULT/DIV accept through the FIX cycle: exactly 33 cycles (32 ITER + 1 FIX).
REQ-017 HI/LO SHALL update only on the edge that leaves FIX; busy falls on the same edge and done is high for the following cycle.
REQ-018 The multiply SHALL be radix-2 shift-add on operand magnitudes.
- MULT takes magnitudes of the two's-complement operands and negates the 64-bit product in FIX when the signs differ.
- MULTU uses raw operands.
- Result {HI,LO} is the 64-bit product.
REQ-019 The divide SHALL be radix-2 restoring on magnitudes.
- LO is the quotient and HI the remainder.
- DIV: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Sign correction happens in FIX.
REQ-020 A divisor of 0 SHALL still take the full 33 cycles and produce HI=A, LO=32'hFFFFFFFF.
REQ-021 DIV 32'h80000000 / 32'hFFFFFFFF SHALL produce LO=32'h80000000, HI=0.
REQ-022 A 5-bit iteration counter SHALL load 31 on accept, decrement once per ITER cycle, and ITER SHALL exit at count 0 (no wrap).
REQ-023 flush high in ITER or FIX SHALL return the block to IDLE on that edge, leave HI/LO unchanged, suppress done, and drop busy on the next cycle.
REQ-024 flush in IDLE SHALL have no effect.
REQ-025 flush together with start in IDLE SHALL discard the start.
REQ-026 Reserved ctrl codes SHALL be accepted as no-ops: no state change, no busy.

Reset
REQ-027 reset low SHALL asynchronously force the following, including mid-operation:
- state IDLE, counter 0;
- HI=0, LO=0;
- busy=0, done=0.
REQ-028 Operation SHALL resume on the first rising clk after reset deasserts.

Configuration
REQ-029 Macro HILO_SEQUENCER_DIV_EN SHALL gate the divider.
- Defined: the divider datapath is compiled in and DIV/DIVU behave as above.
- Undefined: no divider logic; ctrl 2-3 act as reserved no-ops (HI/LO unchanged, no busy, no done).

Verification
REQ-030 MULT A=32'hFFFFFFFE B=3 -> busy 33 cycles, then HI=32'hFFFFFFFF LO=32'hFFFFFFFA, one done pulse.
REQ-031 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE LO=32'h00000001.
REQ-032 DIV A=32'hFFFFFFF9 (-7) B=2 -> LO=32'hFFFFFFFD HI=32'hFFFFFFFF.
REQ-033 DIVU A=100 B=0 -> HI=100 LO=32'hFFFFFFFF after 33 busy cycles; with macro undefined -> HI/LO unchanged, busy never rises.
REQ-034 Control boundaries:
- MULT accepted, start+MTHI at busy cycle 5 -> ignored.
- flush at busy cycle 10 -> HI/LO hold their prior values, busy low next cycle, no done.
REQ-035 reset driven low at busy cycle 20 (asynchronous, between edges) -> busy=0, HI=LO=0 immediately; a MULT after release completes normally.
